// File: rtl/adc_capture_ctrl_if.sv
// Sample-path bundle for the capture controller: the ADC write strobe/data
// coming in and the capture RAM write port going out.
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              sample_ready;
  logic [DATA_W-1:0] sample_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Producer side: drives ADC samples, observes the RAM write port.
  modport master (
    output sample_ready,
    output sample_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  // Controller side: consumes ADC samples, drives the RAM write port.
  modport slave (
    input  sample_ready,
    input  sample_data,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: circular pre-trigger recording into a DEPTH-entry RAM,
// level-crossing trigger, post-trigger fill, then a done flag and pulse.
module adc_capture_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int PRETRIG = 64
) (
  input  logic                 osc_clk,
  input  logic                 reset,
  adc_capture_ctrl_if.slave    bus,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [1:0]           trig_mode,
  input  logic [DATA_W-1:0]    trig_level,
  output logic                 busy,
  output logic                 done,
  output logic                 done_irq,
  output logic [ADDR_W-1:0]    start_addr,
  output logic [ADDR_W-1:0]    trig_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] PRE_C     = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(DEPTH - PRETRIG - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [DATA_W-1:0]   prev_sample_q, prev_sample_d;
  logic                prev_vld_q, prev_vld_d;
  logic                rdy_q;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                done_irq_q, done_irq_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;

  logic                stb;
  logic                rise_hit;
  logic                fall_hit;
  logic                edge_hit;
  logic                trig_fire;

  // Rising edge of the ADC write enable marks one new sample; the trigger
  // is only eligible once the pre-trigger window is full and, for edge
  // modes, once a previous sample exists to compare against.
  always_comb begin
    stb      = bus.sample_ready & ~rdy_q;
    rise_hit = (prev_sample_q < trig_level) && (bus.sample_data >= trig_level);
    fall_hit = (prev_sample_q > trig_level) && (bus.sample_data <= trig_level);
    edge_hit = 1'b0;
    case (trig_mode)
      2'b00:   edge_hit = 1'b1;
      2'b01:   edge_hit = rise_hit;
      2'b10:   edge_hit = fall_hit;
      default: edge_hit = rise_hit | fall_hit;
    endcase
    trig_fire = (fill_cnt_q == PRE_C) && ((trig_mode == 2'b00) || prev_vld_q) && edge_hit;
  end

  // Next-state, write-port and status computation; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    post_cnt_d    = post_cnt_q;
    prev_sample_d = prev_sample_q;
    prev_vld_d    = prev_vld_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    start_addr_d  = start_addr_q;
    trig_addr_d   = trig_addr_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d    = S_ARMED;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
            prev_vld_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (stb) begin
            mem_we_d      = 1'b1;
            mem_addr_d    = wr_ptr_q;
            mem_wdata_d   = bus.sample_data;
            wr_ptr_d      = wr_ptr_q + 1'b1;
            prev_sample_d = bus.sample_data;
            prev_vld_d    = 1'b1;
            if (trig_fire) begin
              trig_addr_d  = wr_ptr_q;
              start_addr_d = wr_ptr_q - PRE_C;
              post_cnt_d   = POST_INIT;
              state_d      = (POST_INIT == '0) ? S_DONE : S_CAPTURE;
            end else if (fill_cnt_q != PRE_C) begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (stb) begin
            mem_we_d      = 1'b1;
            mem_addr_d    = wr_ptr_q;
            mem_wdata_d   = bus.sample_data;
            wr_ptr_d      = wr_ptr_q + 1'b1;
            prev_sample_d = bus.sample_data;
            post_cnt_d    = post_cnt_q - 1'b1;
            if (post_cnt_q == ADDR_W'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d     = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d     = (state_d == S_DONE);
    done_irq_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // All state and registered outputs, with synchronous reset.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      post_cnt_q    <= '0;
      prev_sample_q <= '0;
      prev_vld_q    <= 1'b0;
      rdy_q         <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_irq_q    <= 1'b0;
      start_addr_q  <= '0;
      trig_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_cnt_q    <= fill_cnt_d;
      post_cnt_q    <= post_cnt_d;
      prev_sample_q <= prev_sample_d;
      prev_vld_q    <= prev_vld_d;
      rdy_q         <= bus.sample_ready;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      done_irq_q    <= done_irq_d;
      start_addr_q  <= start_addr_d;
      trig_addr_q   <= trig_addr_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign done_irq      = done_irq_q;
  assign start_addr    = start_addr_q;
  assign trig_addr     = trig_addr_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl against a sample-index model.
module tb_adc_capture_ctrl;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;
  localparam int PRETRIG = 64;

  logic              osc_clk = 1'b0;
  logic              reset;
  logic              arm;
  logic              abort;
  logic [1:0]        trig_mode;
  logic [DATA_W-1:0] trig_level;
  logic              busy;
  logic              done;
  logic              done_irq;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] trig_addr;

  adc_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  adc_capture_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG)
  ) dut (
    .osc_clk(osc_clk), .reset(reset), .bus(bus.slave),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level),
    .busy(busy), .done(done), .done_irq(done_irq),
    .start_addr(start_addr), .trig_addr(trig_addr)
  );

  // Free-running system clock.
  always #5 osc_clk = ~osc_clk;

  int errors = 0;
  int checks = 0;

  // Model: a capture is the sequence of strobed samples since arm; sample i
  // lands at address i mod DEPTH, the trigger index is the first eligible
  // crossing, and the capture ends after DEPTH-PRETRIG samples from it.
  int m_active, m_done, m_count, m_trig, m_prev;
  int exp_we, exp_addr, exp_data, exp_irq;
  int write_cnt, irq_cnt, last_addr;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic checkCycle();
    checkOutput("mem_we", 32'(bus.mem_we), exp_we);
    if (exp_we != 0) begin
      checkOutput("mem_addr", 32'(bus.mem_addr), exp_addr);
      checkOutput("mem_wdata", 32'(bus.mem_wdata), exp_data);
    end
    checkOutput("busy", 32'(busy), m_active);
    checkOutput("done", 32'(done), m_done);
    checkOutput("done_irq", 32'(done_irq), exp_irq);
    if (m_done != 0) begin
      checkOutput("trig_addr", 32'(trig_addr), m_trig % DEPTH);
      checkOutput("start_addr", 32'(start_addr), (((m_trig - PRETRIG) % DEPTH) + DEPTH) % DEPTH);
    end
    if (bus.mem_we) begin
      write_cnt++;
      last_addr = int'(bus.mem_addr);
    end
    if (done_irq) irq_cnt++;
    exp_we  = 0;
    exp_irq = 0;
  endtask

  function automatic int crossHit(input int prev, input int cur, input int mode, input int lvl);
    int rise, fall;
    rise = (prev < lvl && cur >= lvl) ? 1 : 0;
    fall = (prev > lvl && cur <= lvl) ? 1 : 0;
    case (mode)
      0:       return 1;
      1:       return rise;
      2:       return fall;
      default: return rise | fall;
    endcase
  endfunction

  // One ADC sample: a single-cycle write-enable pulse followed by idle gap.
  task automatic applyStimulus(input logic [DATA_W-1:0] v);
    int gaps;
    bus.sample_ready = 1'b1;
    bus.sample_data  = v;
    if (m_active != 0) begin
      exp_we   = 1;
      exp_addr = m_count % DEPTH;
      exp_data = int'(v);
      if (m_trig < 0 && m_count >= PRETRIG) begin
        if (int'(trig_mode) == 0 || m_count > 0) begin
          if (crossHit(m_prev, int'(v), int'(trig_mode), int'(trig_level)) != 0) m_trig = m_count;
        end
      end
      m_prev = int'(v);
      m_count++;
      if (m_trig >= 0 && m_count == m_trig + DEPTH - PRETRIG) begin
        m_active = 0;
        m_done   = 1;
        exp_irq  = 1;
      end
    end
    stepCycle();
    checkCycle();
    bus.sample_ready = 1'b0;
    gaps = int'($urandom_range(0, 2));
    repeat (1 + gaps) begin
      stepCycle();
      checkCycle();
    end
  endtask

  task automatic pulseArm(input logic with_abort);
    arm   = 1'b1;
    abort = with_abort;
    if (with_abort) begin
      m_active = 0;
      m_done   = 0;
    end else if (m_active == 0) begin
      m_active = 1;
      m_done   = 0;
      m_count  = 0;
      m_trig   = -1;
    end
    stepCycle();
    checkCycle();
    arm   = 1'b0;
    abort = 1'b0;
    stepCycle();
    checkCycle();
  endtask

  initial begin
    int n;
    reset = 1'b1; arm = 1'b0; abort = 1'b0;
    trig_mode = 2'b00; trig_level = '0;
    bus.sample_ready = 1'b0; bus.sample_data = '0;
    m_active = 0; m_done = 0; m_count = 0; m_trig = -1; m_prev = 0;
    exp_we = 0; exp_addr = 0; exp_data = 0; exp_irq = 0;
    write_cnt = 0; irq_cnt = 0; last_addr = -1;

    // Reset held with the ADC strobing: nothing may come out.
    for (int i = 0; i < 3; i++) begin
      bus.sample_ready = ~bus.sample_ready;
      bus.sample_data  = 8'($urandom);
      stepCycle();
      checkCycle();
      checkOutput("rst_trig_addr", 32'(trig_addr), 0);
    end
    bus.sample_ready = 1'b0;
    reset = 1'b0;
    stepCycle();
    checkCycle();
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));

    // Immediate trigger: 300 strobes, exactly DEPTH writes, one done pulse.
    trig_mode = 2'b00;
    write_cnt = 0; irq_cnt = 0;
    pulseArm(1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(8'($urandom));
    checkOutput("imm_writes", 32'(write_cnt), 256);
    checkOutput("imm_irqs", 32'(irq_cnt), 1);
    checkOutput("imm_trig_addr", 32'(trig_addr), 64);
    checkOutput("imm_start_addr", 32'(start_addr), 0);

    // Rising at 0x80: crossings inside the prefill must be ignored.
    trig_mode = 2'b01; trig_level = 8'h80;
    pulseArm(1'b0);
    for (int i = 0; i < 64; i++) applyStimulus(((i % 2) == 0) ? 8'h00 : 8'hFF);
    for (int i = 0; i < 256; i++) applyStimulus(8'(i));
    n = 0;
    while (m_active != 0 && n < 1000) begin applyStimulus(8'($urandom)); n++; end
    checkOutput("rise_done", 32'(done), 1);
    checkOutput("rise_trig_addr", 32'(trig_addr), 192);
    checkOutput("rise_start_addr", 32'(start_addr), 128);

    // Long pre-trigger run: write pointer wraps before the trigger.
    pulseArm(1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(8'h00);
    applyStimulus(8'h90);
    n = 0;
    while (m_active != 0 && n < 1000) begin applyStimulus(8'($urandom)); n++; end
    checkOutput("wrap_trig_addr", 32'(trig_addr), 44);
    checkOutput("wrap_start_addr", 32'(start_addr), 236);
    checkOutput("wrap_last_addr", 32'(last_addr), 235);

    // Abort together with arm mid-capture lands in idle; later strobes ignored.
    trig_mode = 2'b00;
    pulseArm(1'b0);
    for (int i = 0; i < 80; i++) applyStimulus(8'($urandom));
    pulseArm(1'b1);
    checkOutput("abort_busy", 32'(busy), 0);
    write_cnt = 0;
    applyStimulus(8'h55);
    checkOutput("abort_writes", 32'(write_cnt), 0);

    // Falling at 0x40: a flat 0x40 input is no crossing; 0x50 -> 0x40 is.
    trig_mode = 2'b10; trig_level = 8'h40;
    pulseArm(1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(8'h40);
    checkOutput("fall_still_busy", 32'(busy), 1);
    applyStimulus(8'h50);
    applyStimulus(8'h40);
    n = 0;
    while (m_active != 0 && n < 1000) begin applyStimulus(8'($urandom)); n++; end
    checkOutput("fall_trig_addr", 32'(trig_addr), 101);

    // Random captures, re-armed straight from done.
    for (int r = 0; r < 3; r++) begin
      trig_mode  = 2'($urandom);
      trig_level = 8'($urandom_range(16, 239));
      pulseArm(1'b0);
      n = 0;
      while (m_active != 0 && n < 3000) begin applyStimulus(8'($urandom)); n++; end
      checkOutput("rnd_done", 32'(done), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
